// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fullAdder cell, LSB first, with valid/ready handshakes on both sides.
// Define SERIAL_ADDER_OVF_EN to add a registered signed-overflow output.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cOut;
    logic             w_cellSum;
    logic             w_cellCarry;
    logic             w_accept;
    logic             w_lastBit;
    logic [WIDTH-1:0] w_aNext;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_lastBit = (r_cnt == CW'(WIDTH - 1));

    fullAdder u_cell (
        .i_a     (r_aSh[0]),
        .i_b     (r_bSh[0]),
        .i_cIn   (r_carry),
        .o_sum   (w_cellSum),
        .o_carry (w_cellCarry)
    );

    // Sum bits enter at the MSB of the A shifter as A bits leave at the LSB,
    // so after WIDTH shifts this register holds the complete result.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign w_aNext = w_cellSum;
        end else begin : g_wide
            assign w_aNext = {w_cellSum, r_aSh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_nextState = SHIFT;
            SHIFT:   if (w_lastBit) w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aSh   <= '0;
            r_bSh   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cOut  <= 1'b0;
        end else if (w_accept) begin
            r_aSh   <= a;
            r_bSh   <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_aSh   <= w_aNext;
            r_bSh   <= r_bSh >> 1;
            r_carry <= w_cellCarry;
            r_cnt   <= r_cnt + CW'(1);
            if (w_lastBit) begin
                r_sum  <= w_aNext;
                r_cOut <= w_cellCarry;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last bit r_carry is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == SHIFT) && w_lastBit) begin
            r_ovf <= r_carry ^ w_cellCarry;
        end
    end

    assign overflow = r_ovf;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == SHIFT);
    assign sum       = r_sum;
    assign c_out     = r_cOut;

    a_inValidKnown: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == IDLE) |-> !$isunknown(in_valid));
    a_outReadyKnown: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == DONE) |-> !$isunknown(out_ready));

endmodule

module fullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cIn,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b ^ i_cIn;
    assign o_carry = (i_a & i_b) | (i_cIn & (i_a ^ i_b));
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios and a 1-bit instance
// for the exhaustive single-bit truth table.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
    logic [7:0] a, b, sum;

    logic       in_valid1, in_ready1, c_in1, out_valid1, out_ready1, c_out1, busy1;
    logic [0:0] a1, b1, sum1;

`ifdef SERIAL_ADDER_OVF_EN
    logic       overflow, overflow1;
`endif

    int checks   = 0;
    int failures = 0;
    int lat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .c_in      (c_in1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .c_out     (c_out1),
        .busy      (busy1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow  (overflow1)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents operands for one accepting edge, then scrambles them to prove they are not resampled.
    task automatic startOp(input logic [7:0] aV, input logic [7:0] bV, input logic cV);
        @(negedge clk);
        a = aV; b = bV; c_in = cV; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = ~aV; b = ~bV; c_in = ~cV;
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] aV, input logic [7:0] bV, input logic cV,
                                 input logic [7:0] expSum, input logic expC, input logic expOvf);
        startOp(aV, bV, cV);
        waitDone(lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd8);
        checkOutput({tag, "_sum"}, 64'(sum), 64'(expSum));
        checkOutput({tag, "_cout"}, 64'(c_out), 64'(expC));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput({tag, "_ovf"}, 64'(overflow), 64'(expOvf));
`else
        if (expOvf === 1'bx) $display("[TB] unexpected X overflow reference in %s", tag);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    task automatic applyStimulus1(input int idx, input logic aV, input logic bV, input logic cV, input logic [1:0] expVal);
        int edges;
        @(negedge clk);
        a1 = aV; b1 = bV; c_in1 = cV; in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0; a1 = ~aV; b1 = ~bV; c_in1 = ~cV;
        edges = 0;
        while (!out_valid1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput($sformatf("w1_lat_%0d", idx), 64'(edges), 64'd1);
        checkOutput($sformatf("w1_res_%0d", idx), 64'({c_out1, sum1}), 64'(expVal));
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
    endtask

    initial begin
        logic [1:0] w1Exp [8];
        w1Exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        $display("[TB] reset released");
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_cout", 64'(c_out), 64'd0);

        applyStimulus("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus("5a_a5", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0);
        applyStimulus("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        applyStimulus("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        applyStimulus("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Backpressure: result held for five cycles while a stray request is ignored.
        startOp(8'h3C, 8'h0F, 1'b0);
        waitDone(lat);
        checkOutput("bp_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_sum_%0d", i), 64'(sum), 64'h4B);
            checkOutput($sformatf("bp_cout_%0d", i), 64'(c_out), 64'd0);
            checkOutput($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
            checkOutput($sformatf("bp_out_valid_%0d", i), 64'(out_valid), 64'd1);
            if (i == 2) begin
                in_valid = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_release_busy", 64'(busy), 64'd0);
        checkOutput("bp_release_sum_held", 64'(sum), 64'h4B);

        // Asynchronous reset in the middle of a shift.
        startOp(8'h11, 8'h22, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("midrst_busy_before", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_sum", 64'(sum), 64'd0);
        checkOutput("midrst_cout", 64'(c_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        applyStimulus("after_rst", 8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 1'b0);
        applyStimulus("ff_01_ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] combo;
            combo = 3'(i);
            applyStimulus1(i, combo[2], combo[1], combo[0], w1Exp[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
